// File: rtl/cpu_seq.sv
// cpu_seq: multicycle sequencer owning PC, GPR file and control FSM.
// Optional performance counters are built when CPU_PERF_CNT_EN is defined.
module cpu_seq #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     NREGS    = 32,
  parameter int unsigned     AW       = 14,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic                     o_imem_req,
  output logic [AW-1:0]            o_imem_addr,
  input  logic                     i_imem_ack,
  input  logic [31:0]              i_imem_data,
  output logic [31:0]              o_insn,
  output logic [NREGS*XLEN-1:0]    o_gpr,
  input  logic                     i_dcd_valid,
  input  logic [3:0]               i_dcd_to_state,
  input  logic [3:0]               i_dcd_alu_op,
  input  logic [XLEN-1:0]          i_dcd_src1,
  input  logic [XLEN-1:0]          i_dcd_src2,
  input  logic [$clog2(NREGS)-1:0] i_dcd_dst,
  output logic [3:0]               o_alu_op,
  output logic [XLEN-1:0]          o_alu_src1,
  output logic [XLEN-1:0]          o_alu_src2,
  input  logic [XLEN-1:0]          i_alu_dest,
  output logic                     o_dmem_req,
  output logic                     o_dmem_we,
  output logic [AW-1:0]            o_dmem_addr,
  output logic [XLEN-1:0]          o_dmem_wdata,
  input  logic                     i_dmem_ack,
  input  logic [XLEN-1:0]          i_dmem_rdata,
  output logic [XLEN-1:0]          o_pc,
  output logic [3:0]               o_state,
  output logic                     o_trap,
  output logic [63:0]              o_cycles,
  output logic [63:0]              o_retired
);

  localparam int unsigned RW = $clog2(NREGS);

  typedef enum logic [3:0] {
    S_FETCH       = 4'd0,
    S_FETCH_WAIT  = 4'd1,
    S_DECODE      = 4'd2,
    S_EXECUTE     = 4'd3,
    S_SRC1_TO_DST = 4'd4,
    S_LOAD        = 4'd5,
    S_LOAD_WAIT   = 4'd6,
    S_STORE       = 4'd7,
    S_STORE_WAIT  = 4'd8,
    S_BRANCH      = 4'd9,
    S_TRAP        = 4'd15
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     insn_q, insn_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [RW-1:0]   dst_q, dst_d;
  logic [XLEN-1:0] gpr_q [NREGS];
  logic            wr_en;
  logic [XLEN-1:0] wr_data;
  logic            dcd_ok;

  // Only the five work states are legal decoder targets.
  always_comb begin
    dcd_ok = 1'b0;
    case (i_dcd_to_state)
      4'd3, 4'd4, 4'd5, 4'd7, 4'd9: dcd_ok = 1'b1;
      default:                      dcd_ok = 1'b0;
    endcase
  end

  // Next-state, latch and register-write selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    insn_d  = insn_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dst_d   = dst_q;
    wr_en   = 1'b0;
    wr_data = '0;
    unique case (state_q)
      S_FETCH: begin
        pc_d    = pc_q + XLEN'(4);
        state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (i_imem_ack) begin
          insn_d  = i_imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d   = i_dcd_alu_op;
        src1_d = i_dcd_src1;
        src2_d = i_dcd_src2;
        dst_d  = i_dcd_dst;
        if (i_dcd_valid && dcd_ok) begin
          state_d = state_e'(i_dcd_to_state);
        end else begin
          state_d = S_TRAP;
        end
      end
      S_EXECUTE: begin
        wr_en   = 1'b1;
        wr_data = i_alu_dest;
        state_d = S_FETCH;
      end
      S_SRC1_TO_DST: begin
        wr_en   = 1'b1;
        wr_data = src1_q;
        state_d = S_FETCH;
      end
      S_LOAD: begin
        state_d = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        if (i_dmem_ack) begin
          wr_en   = 1'b1;
          wr_data = i_dmem_rdata;
          state_d = S_FETCH;
        end
      end
      S_STORE: begin
        state_d = S_STORE_WAIT;
      end
      S_STORE_WAIT: begin
        if (i_dmem_ack) begin
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        wr_en   = 1'b1;
        wr_data = pc_q;
        pc_d    = {i_alu_dest[XLEN-1:2], 2'b00};
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // Control state, PC and decode latches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      insn_q  <= '0;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dst_q   <= dst_d;
    end
  end

  // GPR file; r0 is never written so it stays zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (wr_en && (dst_q != '0)) begin
      gpr_q[dst_q] <= wr_data;
    end
  end

  // Flatten the register file for the decoder.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      o_gpr[i*XLEN +: XLEN] = gpr_q[i];
    end
  end

  assign o_imem_req   = (state_q == S_FETCH);
  assign o_imem_addr  = pc_q[AW+1:2];
  assign o_insn       = insn_q;
  assign o_alu_op     = op_q;
  assign o_alu_src1   = src1_q;
  assign o_alu_src2   = src2_q;
  assign o_dmem_req   = (state_q == S_LOAD) || (state_q == S_STORE);
  assign o_dmem_we    = (state_q == S_STORE);
  assign o_dmem_addr  = i_alu_dest[AW+1:2];
  assign o_dmem_wdata = src2_q;
  assign o_pc         = pc_q;
  assign o_state      = state_q;
  assign o_trap       = (state_q == S_TRAP);

`ifdef CPU_PERF_CNT_EN
  logic [63:0] cycles_q;
  logic [63:0] retired_q;
  logic        retire;

  // FETCH is only re-entered from a completing work state.
  assign retire = (state_q != S_FETCH) && (state_d == S_FETCH);

  // Live-cycle and retired-instruction counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycles_q  <= '0;
      retired_q <= '0;
    end else begin
      if (state_q != S_TRAP) begin
        cycles_q <= cycles_q + 64'd1;
      end
      if (retire) begin
        retired_q <= retired_q + 64'd1;
      end
    end
  end

  assign o_cycles  = cycles_q;
  assign o_retired = retired_q;
`else
  assign o_cycles  = '0;
  assign o_retired = '0;
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: directed vector bench for cpu_seq.
// Bench acts as memories, decoder and ALU.
module tb_cpu_seq;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 14;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n = 1'b0;
  logic                  o_imem_req;
  logic [AW-1:0]         o_imem_addr;
  logic                  i_imem_ack;
  logic [31:0]           i_imem_data;
  logic [31:0]           o_insn;
  logic [NREGS*XLEN-1:0] o_gpr;
  logic                  i_dcd_valid;
  logic [3:0]            i_dcd_to_state;
  logic [3:0]            i_dcd_alu_op;
  logic [XLEN-1:0]       i_dcd_src1;
  logic [XLEN-1:0]       i_dcd_src2;
  logic [4:0]            i_dcd_dst;
  logic [3:0]            o_alu_op;
  logic [XLEN-1:0]       o_alu_src1;
  logic [XLEN-1:0]       o_alu_src2;
  logic [XLEN-1:0]       i_alu_dest;
  logic                  o_dmem_req;
  logic                  o_dmem_we;
  logic [AW-1:0]         o_dmem_addr;
  logic [XLEN-1:0]       o_dmem_wdata;
  logic                  i_dmem_ack;
  logic [XLEN-1:0]       i_dmem_rdata;
  logic [XLEN-1:0]       o_pc;
  logic [3:0]            o_state;
  logic                  o_trap;
  logic [63:0]           o_cycles;
  logic [63:0]           o_retired;

  cpu_seq dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .o_imem_req     (o_imem_req),
    .o_imem_addr    (o_imem_addr),
    .i_imem_ack     (i_imem_ack),
    .i_imem_data    (i_imem_data),
    .o_insn         (o_insn),
    .o_gpr          (o_gpr),
    .i_dcd_valid    (i_dcd_valid),
    .i_dcd_to_state (i_dcd_to_state),
    .i_dcd_alu_op   (i_dcd_alu_op),
    .i_dcd_src1     (i_dcd_src1),
    .i_dcd_src2     (i_dcd_src2),
    .i_dcd_dst      (i_dcd_dst),
    .o_alu_op       (o_alu_op),
    .o_alu_src1     (o_alu_src1),
    .o_alu_src2     (o_alu_src2),
    .i_alu_dest     (i_alu_dest),
    .o_dmem_req     (o_dmem_req),
    .o_dmem_we      (o_dmem_we),
    .o_dmem_addr    (o_dmem_addr),
    .o_dmem_wdata   (o_dmem_wdata),
    .i_dmem_ack     (i_dmem_ack),
    .i_dmem_rdata   (i_dmem_rdata),
    .o_pc           (o_pc),
    .o_state        (o_state),
    .o_trap         (o_trap),
    .o_cycles       (o_cycles),
    .o_retired      (o_retired)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  to;
    logic [4:0]  dst;
    logic [3:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] alu;
    logic [63:0] rdata;
    int          ilat;
    int          dlat;
    logic [13:0] daddr;
    logic [31:0] insn;
    logic [63:0] epc;
    logic [63:0] val;
  } vec_t;

  vec_t        vecs [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          imem_reqs = 0;
  int          dmem_reqs = 0;
  int          overlap = 0;
  int          n_ret = 0;
  logic [63:0] exp_pc = 64'd0;

  always @(posedge i_clk) begin
    if (i_rst_n) begin
      if (o_imem_req) imem_reqs <= imem_reqs + 1;
      if (o_dmem_req) dmem_reqs <= dmem_reqs + 1;
      if (o_imem_req && o_dmem_req) overlap <= overlap + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [63:0] gpr(input int idx);
    return o_gpr[idx*XLEN +: XLEN];
  endfunction

  function automatic vec_t mk(
    input logic [3:0] to, input logic [4:0] dst, input logic [3:0] op,
    input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] alu,
    input logic [63:0] rdata, input int ilat, input int dlat,
    input logic [13:0] daddr, input logic [31:0] insn,
    input logic [63:0] epc, input logic [63:0] val);
    vec_t v;
    v.to = to; v.dst = dst; v.op = op; v.s1 = s1; v.s2 = s2;
    v.alu = alu; v.rdata = rdata; v.ilat = ilat; v.dlat = dlat;
    v.daddr = daddr; v.insn = insn; v.epc = epc; v.val = val;
    return v;
  endfunction

  task automatic fetch_dec(
    input int ilat, input logic [31:0] insn, input logic [3:0] to,
    input logic vld, input logic [63:0] s1, input logic [63:0] s2,
    input logic [4:0] dst, input logic [3:0] op);
    int          r0;
    logic [13:0] wa;
    r0 = imem_reqs;
    wa = exp_pc[15:2];
    check("st_fetch", 64'(o_state), 64'd0);
    check("imem_req", 64'(o_imem_req), 64'd1);
    check("imem_addr", 64'(o_imem_addr), 64'(wa));
    i_imem_ack  = 1'b1;
    i_imem_data = 32'hBAD0_0BAD;
    tick();
    i_imem_ack  = 1'b0;
    i_imem_data = '0;
    for (int i = 1; i < ilat; i++) tick();
    check("st_fwait", 64'(o_state), 64'd1);
    check("imem_req_lo", 64'(o_imem_req), 64'd0);
    i_imem_ack  = 1'b1;
    i_imem_data = insn;
    tick();
    i_imem_ack  = 1'b0;
    check("st_decode", 64'(o_state), 64'd2);
    check("insn", 64'(o_insn), 64'(insn));
    check("pc_inc", o_pc, exp_pc + 64'd4);
    check("imem_pulses", 64'(imem_reqs - r0), 64'd1);
    i_dcd_valid    = vld;
    i_dcd_to_state = to;
    i_dcd_src1     = s1;
    i_dcd_src2     = s2;
    i_dcd_dst      = dst;
    i_dcd_alu_op   = op;
    tick();
    i_dcd_valid    = 1'b0;
    i_dcd_to_state = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int d0;
    logic mem;
    fetch_dec(v.ilat, v.insn, v.to, 1'b1, v.s1, v.s2, v.dst, v.op);
    check("st_work", 64'(o_state), 64'(v.to));
    check("alu_op", 64'(o_alu_op), 64'(v.op));
    check("alu_src1", o_alu_src1, v.s1);
    check("alu_src2", o_alu_src2, v.s2);
    d0 = dmem_reqs;
    mem = (v.to == 4'd5) || (v.to == 4'd7);
    i_alu_dest = v.alu;
    if (mem) begin
      check("dmem_req", 64'(o_dmem_req), 64'd1);
      check("dmem_we", 64'(o_dmem_we), 64'(v.to == 4'd7));
      check("dmem_addr", 64'(o_dmem_addr), 64'(v.daddr));
      if (v.to == 4'd7) check("dmem_wdata", o_dmem_wdata, v.s2);
      tick();
      check("st_mwait", 64'(o_state), 64'(v.to) + 64'd1);
      check("dmem_req_lo", 64'(o_dmem_req), 64'd0);
      for (int i = 1; i < v.dlat; i++) tick();
      i_dmem_ack   = 1'b1;
      i_dmem_rdata = v.rdata;
      tick();
      i_dmem_ack   = 1'b0;
    end else begin
      tick();
    end
    check("st_back", 64'(o_state), 64'd0);
    check("pc_next", o_pc, v.epc);
    check("gpr_dst", gpr(int'(v.dst)), v.val);
    check("gpr_r0", gpr(0), 64'd0);
    check("dmem_pulses", 64'(dmem_reqs - d0), 64'(mem));
    exp_pc = v.epc;
    n_ret++;
  endtask

  task automatic do_reset();
    #1 i_rst_n = 1'b0;
    #1;
    check("rst_state", 64'(o_state), 64'd0);
    check("rst_pc", o_pc, 64'd0);
    check("rst_trap", 64'(o_trap), 64'd0);
    check("rst_gpr", 64'(|o_gpr), 64'd0);
    check("rst_insn", 64'(o_insn), 64'd0);
    check("rst_dreq", 64'(o_dmem_req), 64'd0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    exp_pc = 64'd0;
  endtask

  initial begin
    int r0;
    int d0;
    i_imem_ack = 0; i_imem_data = '0; i_dcd_valid = 0;
    i_dcd_to_state = '0; i_dcd_alu_op = '0; i_dcd_src1 = '0;
    i_dcd_src2 = '0; i_dcd_dst = '0; i_alu_dest = '0;
    i_dmem_ack = 0; i_dmem_rdata = '0;

    vecs[0] = mk(4'd3, 5'd5, 4'h1, 64'h11, 64'h22, 64'h1234, 64'h0,
                 1, 1, 14'h0, 32'h0000_0013, 64'h4, 64'h1234);
    vecs[1] = mk(4'd4, 5'd0, 4'h0, 64'hFFFF, 64'h0, 64'h0, 64'h0,
                 2, 1, 14'h0, 32'h1111_0000, 64'h8, 64'h0);
    vecs[2] = mk(4'd5, 5'd3, 4'h2, 64'h0, 64'h0, 64'hFFFF_0000_0000_0040,
                 64'hDEAD, 7, 3, 14'h10, 32'h2222_0003, 64'hC, 64'hDEAD);
    vecs[3] = mk(4'd7, 5'd3, 4'h3, 64'h0, 64'hBEEF, 64'h84, 64'h5555,
                 3, 1, 14'h21, 32'h3333_0023, 64'h10, 64'hDEAD);
    vecs[4] = mk(4'd4, 5'd7, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0,
                 64'h0, 1, 1, 14'h0, 32'h4444_0000, 64'h14,
                 64'hFFFF_FFFF_FFFF_FFFF);
    vecs[5] = mk(4'd9, 5'd2, 4'h4, 64'h0, 64'h0, 64'h101, 64'h0,
                 1, 1, 14'h0, 32'h5555_006F, 64'h100, 64'h18);
    vecs[6] = mk(4'd9, 5'd1, 4'h4, 64'h0, 64'h0, 64'h203, 64'h0,
                 2, 1, 14'h0, 32'h6666_006F, 64'h200, 64'h104);
    vecs[7] = mk(4'd3, 5'd31, 4'hF, 64'h7, 64'h9,
                 64'hA5A5_0000_0000_5A5A, 64'h0, 1, 1, 14'h0,
                 32'h7777_0033, 64'h204, 64'hA5A5_0000_0000_5A5A);

    repeat (2) @(posedge i_clk);
    #1;
    check("init_state", 64'(o_state), 64'd0);
    check("init_pc", o_pc, 64'd0);
    check("init_gpr", 64'(|o_gpr), 64'd0);
    check("init_trap", 64'(o_trap), 64'd0);
    check("init_cycles", o_cycles, 64'd0);
    check("init_retired", o_retired, 64'd0);
    i_rst_n = 1'b1;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    check("gpr5_kept", gpr(5), 64'h1234);
    check("gpr1_link", gpr(1), 64'h104);
    check("port_overlap", 64'(overlap), 64'd0);
`ifdef CPU_PERF_CNT_EN
    check("retired", o_retired, 64'(n_ret));
`else
    check("cycles_tied", o_cycles, 64'd0);
    check("retired_tied", o_retired, 64'd0);
`endif

    // Decoder rejects the instruction: sticky trap, no traffic.
    fetch_dec(2, 32'hFFFF_FFFF, 4'd3, 1'b0, 64'h0, 64'h0, 5'd6, 4'h0);
    check("trap_state", 64'(o_state), 64'd15);
    check("trap_flag", 64'(o_trap), 64'd1);
    r0 = imem_reqs;
    d0 = dmem_reqs;
    repeat (20) tick();
    check("trap_no_ireq", 64'(imem_reqs - r0), 64'd0);
    check("trap_no_dreq", 64'(dmem_reqs - d0), 64'd0);
    check("trap_held", 64'(o_state), 64'd15);
    do_reset();

    // Valid decode to an illegal target state also traps.
    fetch_dec(1, 32'hCAFE_0001, 4'd6, 1'b1, 64'h0, 64'h0, 5'd6, 4'h0);
    check("bad_to_trap", 64'(o_trap), 64'd1);
    do_reset();

    // Reset in the middle of LOAD_WAIT, then a stale ack.
    run_vec(vecs[0]);
    fetch_dec(1, 32'h2222_0203, 4'd5, 1'b1, 64'h0, 64'h0, 5'd4, 4'h2);
    i_alu_dest = 64'h40;
    check("mid_load", 64'(o_state), 64'd5);
    tick();
    check("mid_lwait", 64'(o_state), 64'd6);
    tick();
    do_reset();
    d0 = dmem_reqs;
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 64'hBAD;
    i_imem_ack   = 1'b1;
    i_imem_data  = 32'hBAD;
    tick();
    i_dmem_ack = 1'b0;
    i_imem_ack = 1'b0;
    check("stale_state", 64'(o_state), 64'd1);
    check("stale_gpr", 64'(|o_gpr), 64'd0);
    check("stale_insn", 64'(o_insn), 64'd0);
    check("stale_dreq", 64'(dmem_reqs - d0), 64'd0);
    check("stale_pc", o_pc, 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
